twotoone_mux_nand_structural: RTL and testbench



---
 rtl/twotoone_mux_nand_structural.sv | 45 ++++
 tb/tb_twotoone_mux_nand_structural.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/twotoone_mux_nand_structural.sv
// 2:1 multiplexer built only from 2-input NAND primitives, with a registered copy of the output.
// The combinational path has no operators; the register clears asynchronously on rst_n low.
module twotoone_mux_nand_structural #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_q
);

  wire             sn;
  wire [WIDTH-1:0] n1;
  wire [WIDTH-1:0] n2;
  wire [WIDTH-1:0] z_w;

  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;

  // Inverted select, shared by every lane.
  nand u_sn (sn, S, S);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    nand u_n1 (n1[i], A[i], sn);
    nand u_n2 (n2[i], B[i], S);
    nand u_z  (z_w[i], n1[i], n2[i]);
  end

  assign Z   = z_w;
  assign z_d = z_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z_q = z_q;

endmodule

// File: tb/tb_twotoone_mux_nand_structural.sv
// Self-checking bench for the NAND-only 2:1 mux: directed steps plus randomized traffic
// compared against a behavioural select/register model.
module tb_twotoone_mux_nand_structural;

  logic       clk;
  logic       rst_n;
  logic       s1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic [0:0] z1;
  logic [0:0] zq1;
  logic       s8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] z8;
  logic [7:0] zq8;

  int n_cmp;
  int n_fail;

  twotoone_mux_nand_structural #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .S     (s1),
    .A     (a1),
    .B     (b1),
    .Z     (z1),
    .Z_q   (zq1)
  );

  twotoone_mux_nand_structural #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .S     (s8),
    .A     (a8),
    .B     (b8),
    .Z     (z8),
    .Z_q   (zq8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain select, no gate structure.
  function automatic logic [7:0] ref_mux(input logic sel, input logic [7:0] a, input logic [7:0] b);
    return sel ? b : a;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_z;
  logic [7:0] exp_q;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    s8 = 1'b0; a8 = 8'h00; b8 = 8'h00;

    // Directed WIDTH=1 steps while reset is held.
    #10;
    s1 = 1'b0; a1 = 1'b0;
    #1 check("t1_z0", {7'b0, z1}, 8'h00);
    check("reset_zq1", {7'b0, zq1}, 8'h00);
    check("reset_zq8", zq8, 8'h00);
    #24;
    s1 = 1'b1; b1 = 1'b1;
    #1 check("t2_z1", {7'b0, z1}, 8'h01);
    #24;
    s1 = 1'b0; a1 = 1'b1;
    #1 check("t3_z1", {7'b0, z1}, 8'h01);
    s1 = 1'b1; b1 = 1'b0;
    #1 check("t3_z0", {7'b0, z1}, 8'h00);

    // Exhaustive sweep; flipping the unselected input must not move Z.
    for (int k = 0; k < 8; k++) begin
      s1 = k[2]; a1 = k[1]; b1 = k[0];
      #1 check("sweep", {7'b0, z1}, ref_mux(s1, {7'b0, a1}, {7'b0, b1}));
      if (s1) a1 = ~a1;
      else    b1 = ~b1;
      #1 check("sweep_unsel", {7'b0, z1}, ref_mux(s1, {7'b0, a1}, {7'b0, b1}));
    end

    // Register under reset: Z follows, Z_q stays 0 across edges.
    @(negedge clk);
    s1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_zq", {7'b0, zq1}, 8'h00);
    check("rst_hold_z", {7'b0, z1}, 8'h01);

    // Release with S=1, B=1; first edge loads 1.
    @(negedge clk);
    s1 = 1'b1; b1 = 1'b1; rst_n = 1'b1;
    #1 check("post_rel_zq", {7'b0, zq1}, 8'h00);
    @(posedge clk); #1;
    check("first_load", {7'b0, zq1}, 8'h01);

    // Async reset between edges.
    #2 rst_n = 1'b0;
    #1 check("async_rst_zq", {7'b0, zq1}, 8'h00);
    check("async_rst_z", {7'b0, z1}, 8'h01);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=8 directed.
    a8 = 8'hA5; b8 = 8'h3C; s8 = 1'b0;
    #1 check("w8_sel_a", z8, 8'hA5);
    @(posedge clk); #1;
    check("w8_q_a", zq8, 8'hA5);
    @(negedge clk);
    s8 = 1'b1;
    #1 check("w8_sel_b", z8, 8'h3C);
    check("w8_q_hold", zq8, 8'hA5);
    @(posedge clk); #1;
    check("w8_q_b", zq8, 8'h3C);

    // Randomized traffic with occasional mid-cycle reset pulses.
    exp_q = 8'h3C;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      s8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      exp_z = ref_mux(s8, a8, b8);
      #1 check("rnd_z", z8, exp_z);
      check("rnd_q_hold", zq8, exp_q);
      if ($urandom_range(0, 7) == 0) begin
        rst_n = 1'b0;
        #1 check("rnd_rst_q", zq8, 8'h00);
        check("rnd_rst_z", z8, exp_z);
        rst_n = 1'b1;
        exp_q = 8'h00;
      end
      @(posedge clk); #1;
      exp_q = exp_z;
      check("rnd_q", zq8, exp_q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
